ddr_req_arbiter: RTL

- Shares the single block-transfer port of ddr_ctrl (ram_en/ram_write/ram_addr/256-bit block/ram_rdy) among three requesters:
  - instruction-cache refill (IC, read-only)
  - data-cache refill/writeback (DC)
  - auxiliary block mover (AUX, loader/debug DMA)
- Sits between cache_manage_unit/aux engine and ddr_ctrl in the pipeline clock domain.
- Fixed priority with an anti-starvation promotion, one outstanding transfer, per-transfer watchdog.

---
 rtl/ddr_req_arbiter_if.sv | 43 ++++
 rtl/ddr_req_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ddr_req_arbiter_if.sv
// rtl/ddr_req_arbiter_if.sv - requester and ddr_ctrl block-port bundle for ddr_req_arbiter
interface ddr_req_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int BLK_W  = 256
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_done;
  logic              dc_req;
  logic              dc_write;
  logic [ADDR_W-1:0] dc_addr;
  logic [BLK_W-1:0]  dc_wdata;
  logic              dc_done;
  logic              aux_req;
  logic              aux_write;
  logic [ADDR_W-1:0] aux_addr;
  logic [BLK_W-1:0]  aux_wdata;
  logic              aux_done;
  logic [BLK_W-1:0]  rdata;
  logic              ram_en;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [BLK_W-1:0]  ram_wdata;
  logic              ram_rdy;
  logic [BLK_W-1:0]  ram_rdata;
  logic [1:0]        gnt_id;
  logic              busy;
  logic              err;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_write, dc_addr, dc_wdata,
           aux_req, aux_write, aux_addr, aux_wdata, ram_rdy, ram_rdata,
    output ic_done, dc_done, aux_done, rdata, ram_en, ram_write, ram_addr,
           ram_wdata, gnt_id, busy, err
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_write, dc_addr, dc_wdata,
           aux_req, aux_write, aux_addr, aux_wdata, ram_rdy, ram_rdata,
    input  ic_done, dc_done, aux_done, rdata, ram_en, ram_write, ram_addr,
           ram_wdata, gnt_id, busy, err
  );
endinterface

// File: rtl/ddr_req_arbiter.sv
// rtl/ddr_req_arbiter.sv - IC/DC/AUX arbiter for the single ddr_ctrl block-transfer port
module ddr_req_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int BLK_W        = 256,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic              clk,
  input  logic              rst,
  ddr_req_arbiter_if.slave  bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [WD_W-1:0]   wd_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic [1:0]        gnt_id_q;
  logic              ram_en_q;
  logic              ram_write_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [BLK_W-1:0]  ram_wdata_q;
  logic [BLK_W-1:0]  rdata_q;
  logic              ic_done_q;
  logic              dc_done_q;
  logic              aux_done_q;
  logic              err_q;

  logic [1:0]        win;
  logic              rdy_ok;
  logic              wd_expire;

  always_comb begin
    win = 2'd0;
    if (bus.aux_req && (starve_cnt >= SC_W'(STARVE_LIMIT))) win = 2'd3;
    else if (bus.dc_req)                                     win = 2'd2;
    else if (bus.ic_req)                                     win = 2'd1;
    else if (bus.aux_req)                                    win = 2'd3;
  end

  // wd_cnt is zero only in the first BUSY cycle, where ddr_ctrl may still show a stale ready
  assign rdy_ok    = bus.ram_rdy && (wd_cnt != '0);
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      starve_cnt  <= '0;
      gnt_id_q    <= 2'd0;
      ram_en_q    <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      ic_done_q   <= 1'b0;
      dc_done_q   <= 1'b0;
      aux_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ic_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
      aux_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.aux_req) starve_cnt <= '0;
          if (win != 2'd0) begin
            state    <= BUSY;
            ram_en_q <= 1'b1;
            gnt_id_q <= win;
            wd_cnt   <= '0;
            case (win)
              2'd1: begin
                ram_addr_q  <= bus.ic_addr;
                ram_write_q <= 1'b0;
                ram_wdata_q <= '0;
              end
              2'd2: begin
                ram_addr_q  <= bus.dc_addr;
                ram_write_q <= bus.dc_write;
                ram_wdata_q <= bus.dc_wdata;
              end
              default: begin
                ram_addr_q  <= bus.aux_addr;
                ram_write_q <= bus.aux_write;
                ram_wdata_q <= bus.aux_wdata;
              end
            endcase
            if (win == 2'd3)
              starve_cnt <= '0;
            else if (bus.aux_req && (starve_cnt < SC_W'(STARVE_LIMIT)))
              starve_cnt <= starve_cnt + SC_W'(1);
          end
        end
        BUSY: begin
          if (rdy_ok || wd_expire) begin
            state      <= DONE;
            ram_en_q   <= 1'b0;
            ic_done_q  <= (gnt_id_q == 2'd1);
            dc_done_q  <= (gnt_id_q == 2'd2);
            aux_done_q <= (gnt_id_q == 2'd3);
            if (rdy_ok && !ram_write_q) rdata_q <= bus.ram_rdata;
            if (!rdy_ok) err_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ic_done   = ic_done_q;
  assign bus.dc_done   = dc_done_q;
  assign bus.aux_done  = aux_done_q;
  assign bus.rdata     = rdata_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_write = ram_write_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.busy      = ram_en_q;
  assign bus.err       = err_q;
endmodule
